// File: rtl/quadrature_decoder_pkg.sv
// Shared constants and types for the quadrature decoder.
// global_constants holds the project-wide count width; quadrature_decoder_pkg
// holds the decoder types and the transition classifier.
// Optional feature macro used elsewhere: QUAD_VELOCITY_EN.

package global_constants;
    localparam int QUAD_COUNT_WIDTH = 32;
endpackage

package quadrature_decoder_pkg;

    typedef logic signed [global_constants::QUAD_COUNT_WIDTH-1:0] count_t;
    typedef logic signed [15:0] velocity_t;

    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } quad_state_t;

    typedef enum logic [1:0] {
        MOVE_NONE,
        MOVE_FWD,
        MOVE_REV,
        MOVE_BAD
    } move_t;

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; a two-bit change is illegal.
    function automatic move_t classifyMove(quad_state_t prevState, quad_state_t curState);
        move_t result;
        logic  isFwd;
        result = MOVE_NONE;
        case (prevState)
            S00:     isFwd = (curState == S01);
            S01:     isFwd = (curState == S11);
            S11:     isFwd = (curState == S10);
            default: isFwd = (curState == S00);
        endcase
        if (prevState == curState) begin
            result = MOVE_NONE;
        end else if ((prevState ^ curState) == 2'b11) begin
            result = MOVE_BAD;
        end else if (isFwd) begin
            result = MOVE_FWD;
        end else begin
            result = MOVE_REV;
        end
        return result;
    endfunction

endpackage

// File: rtl/quadrature_decoder_if.sv
// Status bundle produced by the quadrature decoder.
// velocity / vel_valid are present only when QUAD_VELOCITY_EN is defined.

interface quadrature_decoder_if;
    import quadrature_decoder_pkg::*;

    count_t    count;
    logic      direction;
    logic      step;
    logic      index_seen;
    logic      error;
`ifdef QUAD_VELOCITY_EN
    velocity_t velocity;
    logic      vel_valid;

    modport master (output count, direction, step, index_seen, error, velocity, vel_valid);
    modport slave  (input  count, direction, step, index_seen, error, velocity, vel_valid);
`else
    modport master (output count, direction, step, index_seen, error);
    modport slave  (input  count, direction, step, index_seen, error);
`endif
endinterface

// File: rtl/quadrature_decoder_quad_input_filter.sv
// Two-flop synchronizer followed by a stability filter for one encoder pin.
// The filtered level only moves after FILTER_LEN identical consecutive
// synchronized samples that differ from the current filtered level.

module quad_input_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o
);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic [3:0] stable_q;

    // Synchronize the pin and count how long it has disagreed with the accepted level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            stable_q <= 4'd0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                stable_q <= 4'd0;
            end else if (stable_q == 4'(FILTER_LEN - 1)) begin
                level_q  <= sync2_q;
                stable_q <= 4'd0;
            end else begin
                stable_q <= stable_q + 4'd1;
            end
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: filtered A/B/I inputs, signed 32-bit position
// count, direction, step pulse, sticky index and error flags.
// Define QUAD_VELOCITY_EN to add the windowed velocity measurement.

module quadrature_decoder
    import quadrature_decoder_pkg::*;
#(
    parameter int FILTER_LEN = 3,
    parameter int VEL_PERIOD = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic quad_A,
    input  logic quad_B,
    input  logic quad_I,
    input  logic enable,
    input  logic clear_count,
    input  logic index_clear_en,
    quadrature_decoder_if.master status
);

    logic        aFilt;
    logic        bFilt;
    logic        iFilt;
    quad_state_t curState;
    quad_state_t state_q,    state_d;
    logic        idxPrev_q;
    count_t      count_q,    count_d;
    logic        dir_q,      dir_d;
    logic        step_q,     step_d;
    logic        error_q,    error_d;
    logic        idxSeen_q,  idxSeen_d;
    move_t       move;
    logic        idxRise;

    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) filtA (.clk(clk), .reset(reset), .pin_i(quad_A), .level_o(aFilt));
    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) filtB (.clk(clk), .reset(reset), .pin_i(quad_B), .level_o(bFilt));
    quad_input_filter #(.FILTER_LEN(FILTER_LEN)) filtI (.clk(clk), .reset(reset), .pin_i(quad_I), .level_o(iFilt));

    assign curState = quad_state_t'({aFilt, bFilt});
    assign move     = classifyMove(state_q, curState);
    assign idxRise  = iFilt & ~idxPrev_q;

    // Register the tracked phase state and all decoder outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S00;
            idxPrev_q <= 1'b0;
            count_q   <= '0;
            dir_q     <= 1'b1;
            step_q    <= 1'b0;
            error_q   <= 1'b0;
            idxSeen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idxPrev_q <= iFilt;
            count_q   <= count_d;
            dir_q     <= dir_d;
            step_q    <= step_d;
            error_q   <= error_d;
            idxSeen_q <= idxSeen_d;
        end
    end

    // Next state: clear_count beats index clear, which beats a normal step
    always_comb begin
        state_d   = curState;
        count_d   = count_q;
        dir_d     = dir_q;
        step_d    = 1'b0;
        error_d   = error_q;
        idxSeen_d = idxSeen_q;

        if (enable && move == MOVE_FWD) begin
            count_d = count_q + count_t'(1);
            dir_d   = 1'b1;
            step_d  = 1'b1;
        end else if (enable && move == MOVE_REV) begin
            count_d = count_q - count_t'(1);
            dir_d   = 1'b0;
            step_d  = 1'b1;
        end
        if (move == MOVE_BAD) begin
            error_d = 1'b1;
        end
        if (idxRise) begin
            idxSeen_d = 1'b1;
        end
        if (index_clear_en && idxRise) begin
            count_d = '0;
            dir_d   = dir_q;
            step_d  = 1'b0;
        end
        if (clear_count) begin
            count_d   = '0;
            dir_d     = dir_q;
            step_d    = 1'b0;
            error_d   = 1'b0;
            idxSeen_d = 1'b0;
        end
    end

    assign status.count      = count_q;
    assign status.direction  = dir_q;
    assign status.step       = step_q;
    assign status.index_seen = idxSeen_q;
    assign status.error      = error_q;

`ifdef QUAD_VELOCITY_EN
    localparam int WIN_W = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;

    logic [WIN_W-1:0] win_q;
    velocity_t        acc_q,  acc_d;
    velocity_t        vel_q;
    velocity_t        stepVal;
    logic             velValid_q;
    logic             windowEnd;
    logic             velUp;
    logic             velDown;

    assign velUp     = step_d & dir_d;
    assign velDown   = step_d & ~dir_d;
    assign windowEnd = (win_q == WIN_W'(VEL_PERIOD - 1));
    assign stepVal   = velUp ? velocity_t'(1) : (velDown ? velocity_t'(-1) : velocity_t'(0));

    // Saturating accumulation of the steps applied this cycle
    always_comb begin
        acc_d = acc_q;
        if (velUp && acc_q != 16'sh7FFF) begin
            acc_d = acc_q + velocity_t'(1);
        end else if (velDown && acc_q != 16'sh8000) begin
            acc_d = acc_q - velocity_t'(1);
        end
    end

    // Window timer: latch the total at the boundary and restart with the boundary step
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q      <= '0;
            acc_q      <= '0;
            vel_q      <= '0;
            velValid_q <= 1'b0;
        end else if (windowEnd) begin
            win_q      <= '0;
            vel_q      <= acc_q;
            acc_q      <= stepVal;
            velValid_q <= 1'b1;
        end else begin
            win_q      <= win_q + WIN_W'(1);
            acc_q      <= acc_d;
            velValid_q <= 1'b0;
        end
    end

    assign status.velocity  = vel_q;
    assign status.vel_valid = velValid_q;
`endif

endmodule

// File: tb/tb_quadrature_decoder.sv
// Self-checking bench for quadrature_decoder. A position-index model of the
// encoder (gray order 00,01,11,10) predicts count, direction, error and the
// number of step pulses. Velocity checks run when QUAD_VELOCITY_EN is defined.

module tb_quadrature_decoder;

    localparam int FILTER_LEN = 3;
    localparam int VEL_PERIOD = 100;
    localparam int SETTLE     = FILTER_LEN + 4;
    localparam int LATENCY    = 2 + FILTER_LEN + 1;

    logic clk = 1'b0;
    logic reset;
    logic pinA, pinB, pinI;
    logic enable;
    logic clearCount;
    logic indexClearEn;

    quadrature_decoder_if status();

    quadrature_decoder #(
        .FILTER_LEN(FILTER_LEN),
        .VEL_PERIOD(VEL_PERIOD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .quad_A        (pinA),
        .quad_B        (pinB),
        .quad_I        (pinI),
        .enable        (enable),
        .clear_count   (clearCount),
        .index_clear_en(indexClearEn),
        .status        (status)
    );

    always #5 clk = ~clk;

    int          checksDone   = 0;
    int          checksPassed = 0;
    int          stepSeen     = 0;
    int          modelSteps   = 0;
    int          modelIdx     = 0;
    logic [31:0] modelCount   = 32'd0;
    logic        modelDir     = 1'b1;
    logic        modelError   = 1'b0;

    // Count step pulses well after the edge that produces them
    always @(posedge clk) begin
        #2;
        if (status.step) stepSeen++;
    end

    function automatic logic [1:0] grayCode(int idx);
        case (idx % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksDone++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ab, input logic idx);
        pinA = ab[1];
        pinB = ab[0];
        pinI = idx;
    endtask

    // kind: +1 forward, -1 reverse, 2 simultaneous change of both phases
    task automatic doMove(input int kind);
        if (kind == 2) begin
            modelIdx   = (modelIdx + 2) % 4;
            modelError = 1'b1;
        end else begin
            modelIdx = (modelIdx + kind + 4) % 4;
            if (enable) begin
                modelCount = modelCount + 32'(kind);
                modelDir   = (kind > 0);
                modelSteps++;
            end
        end
        applyStimulus(grayCode(modelIdx), pinI);
        tick(SETTLE);
    endtask

    task automatic pulseClear();
        clearCount = 1'b1;
        tick(1);
        clearCount = 1'b0;
        modelCount = 32'd0;
        modelError = 1'b0;
        tick(1);
    endtask

    // Forward move watched cycle by cycle; optionally clear on the step cycle
    task automatic latencyMove(input bit clearOnStep);
        modelIdx = (modelIdx + 1) % 4;
        applyStimulus(grayCode(modelIdx), pinI);
        for (int i = 1; i <= LATENCY + 2; i++) begin
            if (clearOnStep && i == LATENCY) clearCount = 1'b1;
            tick(1);
            if (clearOnStep) begin
                if (i == LATENCY) begin
                    clearCount = 1'b0;
                    checkOutput("clearStepCount", status.count, 32'd0);
                    checkOutput("clearStepPulse", 32'(status.step), 32'd0);
                end
            end else begin
                checkOutput($sformatf("latencyStep%0d", i), 32'(status.step), 32'(i == LATENCY));
            end
        end
        if (clearOnStep) begin
            modelCount = 32'd0;
            modelError = 1'b0;
        end else begin
            modelCount = modelCount + 32'd1;
            modelDir   = 1'b1;
            modelSteps++;
        end
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "Count"}, status.count, modelCount);
        checkOutput({tag, "Dir"}, 32'(status.direction), 32'(modelDir));
        checkOutput({tag, "Err"}, 32'(status.error), 32'(modelError));
    endtask

    initial begin
        int stepsBefore;
        int kind;
        int r;
        bit got;

        reset        = 1'b1;
        enable       = 1'b1;
        clearCount   = 1'b0;
        indexClearEn = 1'b0;
        applyStimulus(2'b00, 1'b0);
        tick(3);
        checkOutput("resetCount", status.count, 32'd0);
        checkOutput("resetDir", 32'(status.direction), 32'd1);
        checkOutput("resetStep", 32'(status.step), 32'd0);
        checkOutput("resetIndex", 32'(status.index_seen), 32'd0);
        checkOutput("resetErr", 32'(status.error), 32'd0);
`ifdef QUAD_VELOCITY_EN
        checkOutput("resetVel", 32'(status.velocity), 32'd0);
        checkOutput("resetVelValid", 32'(status.vel_valid), 32'd0);
`endif
        reset = 1'b0;
        tick(2);

        $display("[TB] forward and reverse sequences");
        stepsBefore = stepSeen;
        for (int i = 0; i < 4; i++) doMove(1);
        checkModel("fwd4");
        checkOutput("fwd4Value", status.count, 32'd4);
        checkOutput("fwd4Pulses", 32'(stepSeen - stepsBefore), 32'd4);
        for (int i = 0; i < 6; i++) doMove(-1);
        checkModel("rev6");
        checkOutput("rev6Value", status.count, 32'hFFFF_FFFE);

        $display("[TB] glitch rejection and latency");
        stepsBefore = stepSeen;
        pinA = ~pinA;
        tick(FILTER_LEN - 1);
        pinA = ~pinA;
        tick(SETTLE + 2);
        checkOutput("glitchPulses", 32'(stepSeen - stepsBefore), 32'd0);
        checkModel("glitch");
        latencyMove(1'b0);
        checkModel("latency");

        $display("[TB] illegal transition and clear");
        doMove(2);
        checkModel("illegal");
        pulseClear();
        checkModel("cleared");

        $display("[TB] two's complement wrap");
        force dut.count_q = 32'h7FFF_FFFE;
        tick(1);
        release dut.count_q;
        modelCount = 32'h7FFF_FFFE;
        doMove(1);
        checkModel("wrapMax");
        doMove(1);
        checkModel("wrapMin");
        checkOutput("wrapMinValue", status.count, 32'h8000_0000);
        doMove(-1);
        checkModel("wrapBack");

        $display("[TB] clear on the step cycle");
        latencyMove(1'b1);
        tick(2);
        checkModel("clearStep");

        $display("[TB] index clear");
        doMove(1);
        doMove(1);
        checkModel("preIndex");
        indexClearEn = 1'b1;
        applyStimulus(grayCode(modelIdx), 1'b1);
        tick(SETTLE);
        modelCount = 32'd0;
        checkOutput("indexSeen", 32'(status.index_seen), 32'd1);
        checkModel("indexClear");
        applyStimulus(grayCode(modelIdx), 1'b0);
        indexClearEn = 1'b0;
        tick(SETTLE);

        $display("[TB] randomized moves");
        for (int n = 0; n < 40; n++) begin
            enable = ($urandom_range(0, 4) != 0);
            r = int'($urandom_range(0, 9));
            kind = (r < 5) ? 1 : ((r < 9) ? -1 : (enable ? 2 : 1));
            doMove(kind);
            checkModel($sformatf("rand%0d", n));
            if ($urandom_range(0, 14) == 0) begin
                pulseClear();
                checkModel($sformatf("randClr%0d", n));
            end
        end
        enable = 1'b1;
        checkOutput("totalPulses", 32'(stepSeen), 32'(modelSteps));

`ifdef QUAD_VELOCITY_EN
        $display("[TB] velocity window");
        got = 1'b0;
        for (int n = 0; n < 3 * VEL_PERIOD && !got; n++) begin
            tick(1);
            if (status.vel_valid) got = 1'b1;
        end
        checkOutput("velWindowStart", 32'(got), 32'd1);
        for (int i = 0; i < 10; i++) doMove(1);
        got = 1'b0;
        for (int n = 0; n < 3 * VEL_PERIOD && !got; n++) begin
            tick(1);
            if (status.vel_valid) got = 1'b1;
        end
        checkOutput("velWindowEnd", 32'(got), 32'd1);
        checkOutput("velocity10", 32'(status.velocity), 32'd10);
        tick(1);
        checkOutput("velValidPulse", 32'(status.vel_valid), 32'd0);
        checkModel("velocity");
`endif

        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
